// File: rtl/load_use_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : load_use_hazard_ctrl
// Description : Load-use hazard controller for the ID stage of the 32-bit MIPS
//               pipeline. Compares the IF/ID source registers with the
//               destination of a load sitting in ID/EX. On a match it holds PC
//               and IF/ID and injects LOAD_LAT bubbles into ID/EX. A taken
//               branch resolved in EX overrides any stall and flushes IF/ID.
//
// Parameters  : REG_AW   - register address width
//               LOAD_LAT - stall cycles per load-use hazard (1..15)
//               CNT_W    - width of the statistics counters
//
// Ports       : clk, rst_n (async, active-low)
//               if_id_rs, if_id_rt, if_id_uses_rt - source operands in ID
//               id_ex_rt, id_ex_mem_read, id_ex_valid - load in EX
//               branch_taken_ex - branch resolved taken in EX
//               stall, pc_write, if_id_write, if_id_flush - pipeline control
//               stall_cnt, flush_cnt - statistics counters
//
// Build macro : HAZARD_STATS_EN - when defined, the statistics counters are
//               implemented; otherwise both counter outputs are tied to zero.
//
// Revision    : 1.0 - initial release
// ============================================================================
module load_use_hazard_ctrl #(
    parameter int REG_AW   = 5,
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] if_id_rs,
    input  logic [REG_AW-1:0] if_id_rt,
    input  logic              if_id_uses_rt,
    input  logic [REG_AW-1:0] id_ex_rt,
    input  logic              id_ex_mem_read,
    input  logic              id_ex_valid,
    input  logic              branch_taken_ex,
    output logic              stall,
    output logic              pc_write,
    output logic              if_id_write,
    output logic              if_id_flush,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    localparam logic [0:0] c_S_IDLE   = 1'b0;
    localparam logic [0:0] c_S_HOLD   = 1'b1;
    localparam logic [3:0] c_REM_INIT = 4'(LOAD_LAT - 1);
    localparam bit         c_MULTI    = (LOAD_LAT > 1);

    logic [0:0] r_state;
    logic [3:0] r_remain;
    logic [0:0] w_next_state;
    logic [3:0] w_next_remain;

    logic w_hz;
    logic w_stall;
    logic w_pc_write;
    logic w_if_id_write;
    logic w_if_id_flush;

    // A load targeting $zero never produces a usable value, so it never stalls.
    assign w_hz = id_ex_valid & id_ex_mem_read & (id_ex_rt != '0) &
                  ((if_id_rs == id_ex_rt) |
                   (if_id_uses_rt & (if_id_rt == id_ex_rt)));

    always_comb begin
        w_stall       = 1'b0;
        w_pc_write    = 1'b1;
        w_if_id_write = 1'b1;
        w_if_id_flush = 1'b0;
        w_next_state  = r_state;
        w_next_remain = r_remain;

        if (branch_taken_ex) begin
            // Squash the ID instruction and let the branch target be fetched.
            w_if_id_flush = 1'b1;
            w_stall       = 1'b1;
            w_next_state  = c_S_IDLE;
            w_next_remain = 4'd0;
        end else begin
            case (r_state)
                c_S_IDLE: begin
                    if (w_hz) begin
                        w_stall       = 1'b1;
                        w_pc_write    = 1'b0;
                        w_if_id_write = 1'b0;
                        if (c_MULTI) begin
                            w_next_state  = c_S_HOLD;
                            w_next_remain = c_REM_INIT;
                        end
                    end
                end
                c_S_HOLD: begin
                    // EX holds our own bubble here, so the comparison is moot.
                    w_stall       = 1'b1;
                    w_pc_write    = 1'b0;
                    w_if_id_write = 1'b0;
                    w_next_remain = r_remain - 4'd1;
                    if (r_remain <= 4'd1) begin
                        w_next_state  = c_S_IDLE;
                        w_next_remain = 4'd0;
                    end
                end
                default: begin
                    w_next_state  = c_S_IDLE;
                    w_next_remain = 4'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= c_S_IDLE;
            r_remain <= 4'd0;
        end else begin
            r_state  <= w_next_state;
            r_remain <= w_next_remain;
        end
    end

    // While reset is held the pipeline sees plain run-mode controls, even if
    // the operand comparison happens to match.
    assign stall       = rst_n & w_stall;
    assign pc_write    = ~rst_n | w_pc_write;
    assign if_id_write = ~rst_n | w_if_id_write;
    assign if_id_flush = rst_n & w_if_id_flush;

`ifdef HAZARD_STATS_EN
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    // Saturating counters; only reset clears them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_stall && !w_if_id_flush && (r_stall_cnt != {CNT_W{1'b1}}))
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            if (w_if_id_flush && (r_flush_cnt != {CNT_W{1'b1}}))
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_load_use_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_load_use_hazard_ctrl
// Description : Self-checking bench for load_use_hazard_ctrl. Three instances
//               (LOAD_LAT = 1/3/5, the first with 2-bit counters) share one
//               stimulus stream; a cycle-level reference model predicts the
//               pipeline controls and statistics of each one.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_load_use_hazard_ctrl;

`ifdef HAZARD_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] rs, rt, exrt;
    logic       urt, mr, v, br;

    logic [2:0]  o_stall, o_pcw, o_ifw, o_fl;
    logic [1:0]  sc0, fc0;
    logic [15:0] sc1, fc1, sc2, fc2;
    logic [15:0] sc_v [3];
    logic [15:0] fc_v [3];

    always #5 clk = ~clk;

    load_use_hazard_ctrl #(.REG_AW(5), .LOAD_LAT(1), .CNT_W(2)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .if_id_rs(rs), .if_id_rt(rt), .if_id_uses_rt(urt),
        .id_ex_rt(exrt), .id_ex_mem_read(mr), .id_ex_valid(v), .branch_taken_ex(br),
        .stall(o_stall[0]), .pc_write(o_pcw[0]), .if_id_write(o_ifw[0]),
        .if_id_flush(o_fl[0]), .stall_cnt(sc0), .flush_cnt(fc0));
    load_use_hazard_ctrl #(.REG_AW(5), .LOAD_LAT(3), .CNT_W(16)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .if_id_rs(rs), .if_id_rt(rt), .if_id_uses_rt(urt),
        .id_ex_rt(exrt), .id_ex_mem_read(mr), .id_ex_valid(v), .branch_taken_ex(br),
        .stall(o_stall[1]), .pc_write(o_pcw[1]), .if_id_write(o_ifw[1]),
        .if_id_flush(o_fl[1]), .stall_cnt(sc1), .flush_cnt(fc1));
    load_use_hazard_ctrl #(.REG_AW(5), .LOAD_LAT(5), .CNT_W(16)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .if_id_rs(rs), .if_id_rt(rt), .if_id_uses_rt(urt),
        .id_ex_rt(exrt), .id_ex_mem_read(mr), .id_ex_valid(v), .branch_taken_ex(br),
        .stall(o_stall[2]), .pc_write(o_pcw[2]), .if_id_write(o_ifw[2]),
        .if_id_flush(o_fl[2]), .stall_cnt(sc2), .flush_cnt(fc2));

    always_comb begin
        sc_v[0] = {14'd0, sc0};
        fc_v[0] = {14'd0, fc0};
        sc_v[1] = sc1;
        fc_v[1] = fc1;
        sc_v[2] = sc2;
        fc_v[2] = fc2;
    end

    // ---------------- reference model ----------------
    int lat  [3] = '{1, 3, 5};
    int cmax [3] = '{3, 65535, 65535};
    int left [3];      // stall cycles still owed after the current one
    int m_sc [3];
    int m_fc [3];
    int n_cmp = 0;
    int n_bad = 0;

    function automatic logic hz_f();
        return v && mr && (exrt != 0) && ((rs == exrt) || (urt && (rt == exrt)));
    endfunction

    // {stall, pc_write, if_id_write, if_id_flush}
    function automatic logic [3:0] exp_out(int k);
        if (!rst_n) return 4'b0110;
        if (br) return 4'b1111;
        if (left[k] > 0 || hz_f()) return 4'b1000;
        return 4'b0110;
    endfunction

    function automatic logic [3:0] act_out(int k);
        return {o_stall[k], o_pcw[k], o_ifw[k], o_fl[k]};
    endfunction

    function automatic logic [15:0] exp_sc(int k);
        return STATS ? 16'(m_sc[k]) : 16'd0;
    endfunction

    function automatic logic [15:0] exp_fc(int k);
        return STATS ? 16'(m_fc[k]) : 16'd0;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            left[k] = 0;
            m_sc[k] = 0;
            m_fc[k] = 0;
        end
    endtask

    // Advance one clock: the model consumes the inputs present at the edge.
    task automatic adv();
        @(posedge clk);
        for (int k = 0; k < 3; k++) begin
            if (!rst_n) begin
                left[k] = 0; m_sc[k] = 0; m_fc[k] = 0;
            end else if (br) begin
                left[k] = 0;
                if (m_fc[k] < cmax[k]) m_fc[k]++;
            end else if (left[k] > 0) begin
                left[k]--;
                if (m_sc[k] < cmax[k]) m_sc[k]++;
            end else if (hz_f()) begin
                left[k] = lat[k] - 1;
                if (m_sc[k] < cmax[k]) m_sc[k]++;
            end
        end
        #2;
    endtask

    task automatic set_in(input logic [4:0] a_rs, a_rt, input logic a_urt,
                          input logic [4:0] a_exrt, input logic a_mr, a_v, a_br);
        rs = a_rs; rt = a_rt; urt = a_urt; exrt = a_exrt;
        mr = a_mr; v = a_v; br = a_br;
        #2;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        set_in(5'd8, 5'd0, 1'b0, 5'd3, 1'b1, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if (act_out(k) !== 4'b0110) begin
                n_bad++;
                $display("FAIL reset dut%0d outputs got %b exp 0110", k, act_out(k));
            end
            n_cmp++;
            if (sc_v[k] !== 16'd0 || fc_v[k] !== 16'd0) begin
                n_bad++;
                $display("FAIL reset_cnt dut%0d got %0d/%0d exp 0/0", k, sc_v[k], fc_v[k]);
            end
        end
        adv();
        rst_n = 1'b1;
        set_in(5'd1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b1, 1'b0);
        adv();
    endtask

    task automatic test_rs_hazard();
        int cnt [3] = '{0, 0, 0};
        for (int i = 0; i < 8; i++) begin
            if (i == 0) set_in(5'd8, 5'd4, 1'b0, 5'd8, 1'b1, 1'b1, 1'b0);
            else        set_in(5'd8, 5'd4, 1'b0, 5'd8, 1'b0, 1'b0, 1'b0);
            for (int k = 0; k < 3; k++) begin
                cnt[k] += int'(o_stall[k]);
                n_cmp++;
                if (act_out(k) !== exp_out(k)) begin
                    n_bad++;
                    $display("FAIL rs_hazard dut%0d cyc%0d out got %b exp %b", k, i, act_out(k), exp_out(k));
                end
            end
            adv();
        end
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if (cnt[k] != lat[k]) begin
                n_bad++;
                $display("FAIL rs_hazard_len dut%0d got %0d exp %0d", k, cnt[k], lat[k]);
            end
        end
    endtask

    task automatic test_rt_hazard();
        for (int j = 0; j < 2; j++) begin
            int cnt [3] = '{0, 0, 0};
            for (int i = 0; i < 8; i++) begin
                if (i == 0) set_in(5'd3, 5'd9, j == 0, 5'd9, 1'b1, 1'b1, 1'b0);
                else        set_in(5'd3, 5'd9, j == 0, 5'd9, 1'b0, 1'b0, 1'b0);
                for (int k = 0; k < 3; k++) begin
                    cnt[k] += int'(o_stall[k]);
                    n_cmp++;
                    if (act_out(k) !== exp_out(k)) begin
                        n_bad++;
                        $display("FAIL rt_hazard%0d dut%0d cyc%0d out got %b exp %b", j, k, i, act_out(k), exp_out(k));
                    end
                end
                adv();
            end
            for (int k = 0; k < 3; k++) begin
                n_cmp++;
                if (cnt[k] != ((j == 0) ? lat[k] : 0)) begin
                    n_bad++;
                    $display("FAIL rt_hazard%0d_len dut%0d got %0d exp %0d", j, k, cnt[k], (j == 0) ? lat[k] : 0);
                end
            end
        end
    endtask

    task automatic test_no_stall();
        for (int i = 0; i < 4; i++) begin
            if (i < 2) set_in(5'd0, 5'd0, 1'b1, 5'd0, 1'b1, 1'b1, 1'b0);
            else       set_in(5'd7, 5'd7, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0);
            for (int k = 0; k < 3; k++) begin
                n_cmp++;
                if (act_out(k) !== 4'b0110) begin
                    n_bad++;
                    $display("FAIL no_stall dut%0d cyc%0d out got %b exp 0110", k, i, act_out(k));
                end
            end
            adv();
        end
    endtask

    task automatic test_branch_hold();
        for (int i = 0; i < 7; i++) begin
            if (i == 0)      set_in(5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);
            else if (i == 1) set_in(5'd5, 5'd0, 1'b0, 5'd5, 1'b0, 1'b0, 1'b1);
            else             set_in(5'd5, 5'd0, 1'b0, 5'd5, 1'b0, 1'b0, 1'b0);
            for (int k = 0; k < 3; k++) begin
                n_cmp++;
                if (act_out(k) !== exp_out(k)) begin
                    n_bad++;
                    $display("FAIL branch_hold dut%0d cyc%0d out got %b exp %b", k, i, act_out(k), exp_out(k));
                end
                if (i == 1 || i == 2) begin
                    n_cmp++;
                    if (act_out(k) !== ((i == 1) ? 4'b1111 : 4'b0110)) begin
                        n_bad++;
                        $display("FAIL branch_edge dut%0d cyc%0d out got %b exp %b", k, i, act_out(k), (i == 1) ? 4'b1111 : 4'b0110);
                    end
                end
                n_cmp++;
                if (sc_v[k] !== exp_sc(k) || fc_v[k] !== exp_fc(k)) begin
                    n_bad++;
                    $display("FAIL branch_cnt dut%0d cyc%0d got %0d/%0d exp %0d/%0d", k, i, sc_v[k], fc_v[k], exp_sc(k), exp_fc(k));
                end
            end
            adv();
        end
    endtask

    task automatic test_reset_mid_hold();
        set_in(5'd6, 5'd0, 1'b0, 5'd6, 1'b1, 1'b1, 1'b0);
        adv();
        set_in(5'd6, 5'd0, 1'b0, 5'd6, 1'b0, 1'b0, 1'b0);
        // dut1/dut2 are in HOLD and stalling now
        rst_n = 1'b0;
        model_reset();
        #1;
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if (act_out(k) !== 4'b0110 || sc_v[k] !== 16'd0 || fc_v[k] !== 16'd0) begin
                n_bad++;
                $display("FAIL reset_mid_hold dut%0d out got %b cnt %0d/%0d exp 0110 0/0", k, act_out(k), sc_v[k], fc_v[k]);
            end
        end
        adv();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_in(5'd1, 5'd2, 1'b1, 5'd6, 1'b1, 1'b1, 1'b0);
            for (int k = 0; k < 3; k++) begin
                n_cmp++;
                if (act_out(k) !== 4'b0110) begin
                    n_bad++;
                    $display("FAIL after_reset dut%0d cyc%0d out got %b exp 0110", k, i, act_out(k));
                end
            end
            adv();
        end
    endtask

    task automatic test_stats();
        for (int h = 0; h < 5; h++) begin
            for (int i = 0; i < 6; i++) begin
                if (i == 0) set_in(5'd10, 5'd0, 1'b0, 5'd10, 1'b1, 1'b1, 1'b0);
                else        set_in(5'd10, 5'd0, 1'b0, 5'd10, 1'b0, 1'b0, 1'b0);
                adv();
            end
        end
        set_in(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
        adv();
        set_in(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (sc_v[0] !== (STATS ? 16'd3 : 16'd0) || fc_v[0] !== (STATS ? 16'd1 : 16'd0)) begin
            n_bad++;
            $display("FAIL stats_sat dut0 got %0d/%0d exp %0d/%0d", sc_v[0], fc_v[0], STATS ? 3 : 0, STATS ? 1 : 0);
        end
        for (int k = 1; k < 3; k++) begin
            n_cmp++;
            if (sc_v[k] !== (STATS ? 16'(5 * lat[k]) : 16'd0) || fc_v[k] !== (STATS ? 16'd1 : 16'd0)) begin
                n_bad++;
                $display("FAIL stats dut%0d got %0d/%0d exp %0d/%0d", k, sc_v[k], fc_v[k], STATS ? 5 * lat[k] : 0, STATS ? 1 : 0);
            end
        end
        adv();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            set_in(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   $urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0);
            for (int k = 0; k < 3; k++) begin
                n_cmp++;
                if (act_out(k) !== exp_out(k)) begin
                    n_bad++;
                    $display("FAIL random dut%0d cyc%0d out got %b exp %b", k, i, act_out(k), exp_out(k));
                end
                n_cmp++;
                if (sc_v[k] !== exp_sc(k) || fc_v[k] !== exp_fc(k)) begin
                    n_bad++;
                    $display("FAIL random_cnt dut%0d cyc%0d got %0d/%0d exp %0d/%0d", k, i, sc_v[k], fc_v[k], exp_sc(k), exp_fc(k));
                end
            end
            adv();
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_stats();
        test_rs_hazard();
        test_rt_hazard();
        test_no_stall();
        test_branch_hold();
        test_reset_mid_hold();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/load_use_hazard_ctrl.md
# load_use_hazard_ctrl

Parametrised load-use hazard controller for the 32-bit MIPS pipeline, sitting in the ID stage beside the register file. It compares the IF/ID source registers against the destination of a load in ID/EX. On a match it holds PC and IF/ID and injects bubbles into ID/EX for a configurable number of cycles, matching the data-memory load latency. A taken branch resolved in EX overrides any stall and flushes IF/ID.

## Interface
Parameters:
- `REG_AW`, 5: register address width.
- `LOAD_LAT`, 1: stall cycles per load-use hazard; legal range 1..15.
- `CNT_W`, 16: width of the statistics counters.

Ports:
- `clk`  in  1  — the only clock; all state updates on its rising edge.
- `rst_n`  in  1  — asynchronous, active-low reset.
- `if_id_rs`  in  REG_AW  — rs of the instruction in ID.
- `if_id_rt`  in  REG_AW  — rt of the instruction in ID.
- `if_id_uses_rt`  in  1  — the instruction in ID reads rt (R-type, store, branch).
- `id_ex_rt`  in  REG_AW  — destination register of the instruction in EX.
- `id_ex_mem_read`  in  1  — the instruction in EX is a load.
- `id_ex_valid`  in  1  — the EX slot holds a real instruction, not a bubble.
- `branch_taken_ex`  in  1  — a branch resolved taken in EX this cycle.
- `stall`  out  1  — zero the ID/EX control fields (insert a bubble).
- `pc_write`  out  1  — PC update enable.
- `if_id_write`  out  1  — IF/ID register write enable.
- `if_id_flush`  out  1  — clear IF/ID to a NOP.
- `stall_cnt`  out  CNT_W  — total stall cycles (statistics).
- `flush_cnt`  out  CNT_W  — total branch flushes (statistics).

## Operation
- Hazard condition: `hz = id_ex_valid & id_ex_mem_read & (id_ex_rt != 0) & ((if_id_rs == id_ex_rt) | (if_id_uses_rt & (if_id_rt == id_ex_rt)))`.
- A load writing `$zero` never stalls.
- FSM states and transitions:
  - **IDLE**: if `hz` and not `branch_taken_ex`, assert the stall outputs. If `LOAD_LAT > 1`, load `remain = LOAD_LAT-1` and go to **HOLD**; otherwise stay in IDLE.
  - **HOLD**: assert the stall outputs and ignore `hz`, because the EX slot holds the bubble. Decrement `remain` each cycle. When `remain == 1`, go to IDLE on the next edge.
- Stall outputs: `stall=1`, `pc_write=0`, `if_id_write=0`.
- Non-stall outputs: `stall=0`, `pc_write=1`, `if_id_write=1`, `if_id_flush=0`.
- Every output is driven on every path; no latches are permitted.
- `branch_taken_ex` has priority in any state:
  - Outputs: `if_id_flush=1`, `stall=1` (squash the ID instruction), `pc_write=1`, `if_id_write=1`.
  - The FSM returns to IDLE with `remain=0`.
  - `hz` is not evaluated that cycle.
- Outputs are combinational from state and inputs. State and counters are registered.

## Timing
- Reset (asynchronous, while `rst_n=0`):
  - State is IDLE, `remain=0`, both counters 0.
  - Outputs: `stall=0`, `pc_write=1`, `if_id_write=1`, `if_id_flush=0`.
- A hazard presented in cycle N asserts the stall outputs in cycles N..N+LOAD_LAT-1, for exactly LOAD_LAT cycles. Cycle N+LOAD_LAT is a normal cycle.
- A new hazard can be detected in cycle N+LOAD_LAT. Back-to-back dependent loads therefore stall LOAD_LAT cycles each.
- Branch in cycle M during HOLD: flush happens in M, stalling ends in M, and cycle M+1 is in IDLE.
- Reset asserted mid-HOLD: outputs return to their reset values immediately (asynchronously).
- Zero input-to-output latency for detection. One-cycle latency for state and counters.

## Configuration
- `HAZARD_STATS_EN` defined:
  - `stall_cnt` increments on every cycle with `stall=1 & ~if_id_flush`.
  - `flush_cnt` increments on every cycle with `if_id_flush=1`.
  - Both counters saturate at 2^CNT_W-1 and are cleared only by reset.
- `HAZARD_STATS_EN` not defined: the counter logic is omitted and `stall_cnt` and `flush_cnt` are tied to 0. The ports remain present.

## Test plan
- `LOAD_LAT=1`: load to `$8`, then `if_id_rs=8` -> exactly 1 cycle with `stall=1`, `pc_write=0`, `if_id_write=0`; next cycle all normal.
- `LOAD_LAT=3`: load to `$9`, `if_id_rt=9` with `if_id_uses_rt=1` -> 3 stall cycles. The same stimulus with `if_id_uses_rt=0` -> no stall.
- Load to `$0` with `if_id_rs=0`, and separately `id_ex_valid=0` with matching registers -> no stall.
- `LOAD_LAT=3`: `branch_taken_ex=1` in the second stall cycle -> that cycle has `if_id_flush=1`, `pc_write=1`; the following cycle has no stall.
- Drop `rst_n` mid-HOLD -> outputs immediately `stall=0`, `pc_write=1`. After release, a non-hazard input produces no stall.
- With `HAZARD_STATS_EN`, `CNT_W=2`: five hazards at `LOAD_LAT=1` -> `stall_cnt` saturates at 3. One flush -> `flush_cnt=1`. Without the macro -> both counters read 0.
